// File: rtl/even_parity_frame_receiver_if.sv
// Bus between the even-parity frame receiver and its line driver / downstream consumer.
// The master side is the receiver itself; the slave side is the bench or consuming logic.
interface even_parity_frame_receiver_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             rx_bit;
  logic             rx_en;
  logic             ready;
  logic [N-1:0]     data;
  logic             parity;
  logic [N:0]       parity_data;
  logic             valid;
  logic             parity_err;
  logic             frame_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    input  rx_bit, rx_en, ready,
    output data, parity, parity_data, valid, parity_err, frame_err, err_count
  );

  modport slave (
    output rx_bit, rx_en, ready,
    input  data, parity, parity_data, valid, parity_err, frame_err, err_count
  );
endinterface

// File: rtl/even_parity_frame_receiver.sv
// Even-parity frame receiver: start, N data bits LSB first, parity, stop; checked word on valid/ready.
// Optional feature macro PARITY_ERR_CNT_EN builds the saturating errored-frame counter.
module even_parity_frame_receiver #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  even_parity_frame_receiver_if.master  rx_if
);

  localparam int              BC_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [BC_W-1:0] r_bit_cnt;
  logic [N-1:0]    r_data;
  logic            r_parity;
  logic            r_valid;
  logic            r_parity_err;
  logic            r_frame_err;

  logic            w_start;
  logic            w_stop_strobe;
  logic            w_calc_parity_err;
  logic            w_calc_frame_err;

  // Strobe qualifiers and the error results that get latched at the stop sample.
  always_comb begin
    w_start           = 1'b0;
    w_stop_strobe     = 1'b0;
    w_calc_parity_err = 1'b0;
    w_calc_frame_err  = 1'b0;
    if (r_state == S_IDLE) begin
      w_start = rx_if.rx_en & ~rx_if.rx_bit;
    end else begin
      w_start = 1'b0;
    end
    if (r_state == S_STOP) begin
      w_stop_strobe = rx_if.rx_en;
    end else begin
      w_stop_strobe = 1'b0;
    end
    w_calc_parity_err = ^{r_parity, r_data};
    w_calc_frame_err  = ~rx_if.rx_bit;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; cycles without rx_en leave the frame where it is.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_state = S_DATA;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_if.rx_en && (r_bit_cnt == LAST_BIT)) begin
          w_next_state = S_PARITY;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_PARITY: begin
        if (rx_if.rx_en) begin
          w_next_state = S_STOP;
        end else begin
          w_next_state = S_PARITY;
        end
      end
      S_STOP: begin
        if (rx_if.rx_en) begin
          w_next_state = S_HOLD;
        end else begin
          w_next_state = S_STOP;
        end
      end
      S_HOLD: begin
        if (rx_if.ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_HOLD;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Deserializer, parity capture and result flags; everything is frozen while in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= {BC_W{1'b0}};
      r_data       <= {N{1'b0}};
      r_parity     <= 1'b0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_bit_cnt <= {BC_W{1'b0}};
          end
        end
        S_DATA: begin
          if (rx_if.rx_en) begin
            r_data[r_bit_cnt] <= rx_if.rx_bit;
            r_bit_cnt         <= r_bit_cnt + BC_W'(1);
          end
        end
        S_PARITY: begin
          if (rx_if.rx_en) begin
            r_parity <= rx_if.rx_bit;
          end
        end
        S_STOP: begin
          if (rx_if.rx_en) begin
            r_parity_err <= w_calc_parity_err;
            r_frame_err  <= w_calc_frame_err;
            r_valid      <= 1'b1;
          end
        end
        S_HOLD: begin
          if (rx_if.ready) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_err_count;

  // Counts errored frames once, as they enter HOLD, and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= {CNT_W{1'b0}};
    end else if (w_stop_strobe && (w_calc_parity_err || w_calc_frame_err)
                 && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign rx_if.err_count = r_err_count;
`else
  assign rx_if.err_count = {CNT_W{1'b0}};
`endif

  assign rx_if.data        = r_data;
  assign rx_if.parity      = r_parity;
  assign rx_if.parity_data = {r_parity, r_data};
  assign rx_if.valid       = r_valid;
  assign rx_if.parity_err  = r_parity_err;
  assign rx_if.frame_err   = r_frame_err;

endmodule

// File: tb/tb_even_parity_frame_receiver.sv
// Randomized self-checking bench for even_parity_frame_receiver against a frame-level reference model.
// Build with or without PARITY_ERR_CNT_EN; the model follows the same macro.
module tb_even_parity_frame_receiver;
  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_cnt;

  even_parity_frame_receiver_if #(.N(N), .CNT_W(CNT_W)) bus ();

  even_parity_frame_receiver #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, then look at outputs 1 time unit after the edge.
  task automatic drive(input logic en, input logic b, input logic rdy);
    bus.rx_en  = en;
    bus.rx_bit = b;
    bus.ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gmin, input int gmax);
    int g;
    g = $urandom_range(gmax, gmin);
    for (int i = 0; i < g; i++) drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    drive(1'b1, b, 1'($urandom_range(1, 0)));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".valid"}, 32'(bus.valid), 32'd0);
    check_eq({tag, ".data"}, 32'(bus.data), 32'd0);
    check_eq({tag, ".parity"}, 32'(bus.parity), 32'd0);
    check_eq({tag, ".pdata"}, 32'(bus.parity_data), 32'd0);
    check_eq({tag, ".perr"}, 32'(bus.parity_err), 32'd0);
    check_eq({tag, ".ferr"}, 32'(bus.frame_err), 32'd0);
    check_eq({tag, ".cnt"}, 32'(bus.err_count), 32'd0);
  endtask

  // Sends one whole frame, checks the result the cycle after the stop strobe, then handshakes.
  task automatic run_frame(input logic [N-1:0] d, input logic p, input logic s,
                           input int gmin, input int gmax, input int hold, input string tag);
    logic exp_pe;
    logic exp_fe;
    strobe(1'b0, gmin, gmax);
    for (int i = 0; i < N; i++) strobe(d[i], gmin, gmax);
    strobe(p, gmin, gmax);
    check_eq({tag, ".busy_valid"}, 32'(bus.valid), 32'd0);
    strobe(s, gmin, gmax);
    exp_pe = ^{p, d};
    exp_fe = ~s;
    if (exp_pe || exp_fe) begin
`ifdef PARITY_ERR_CNT_EN
      if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
    end
    check_eq({tag, ".valid"}, 32'(bus.valid), 32'd1);
    check_eq({tag, ".data"}, 32'(bus.data), 32'(d));
    check_eq({tag, ".parity"}, 32'(bus.parity), 32'(p));
    check_eq({tag, ".pdata"}, 32'(bus.parity_data), 32'({p, d}));
    check_eq({tag, ".perr"}, 32'(bus.parity_err), 32'(exp_pe));
    check_eq({tag, ".ferr"}, 32'(bus.frame_err), 32'(exp_fe));
    check_eq({tag, ".cnt"}, 32'(bus.err_count), 32'(exp_cnt));
    for (int h = 0; h < hold; h++) begin
      drive(1'b1, 1'b0, 1'b0);
      check_eq({tag, ".hold_valid"}, 32'(bus.valid), 32'd1);
      check_eq({tag, ".hold_pdata"}, 32'(bus.parity_data), 32'({p, d}));
      check_eq({tag, ".hold_flags"}, 32'({bus.parity_err, bus.frame_err}), 32'({exp_pe, exp_fe}));
      check_eq({tag, ".hold_cnt"}, 32'(bus.err_count), 32'(exp_cnt));
    end
    drive(1'b1, 1'b0, 1'b1);
    check_eq({tag, ".hs_valid"}, 32'(bus.valid), 32'd0);
    check_eq({tag, ".hs_cnt"}, 32'(bus.err_count), 32'(exp_cnt));
  endtask

  initial begin
    logic [N-1:0] d;
    logic         p;
    logic         s;
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 0;
    rst = 1'b1;
    bus.rx_en  = 1'b0;
    bus.rx_bit = 1'b1;
    bus.ready  = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    check_reset_state("reset");

    run_frame(4'b1011, 1'b1, 1'b1, 0, 0, 0, "good");
    run_frame(4'b0110, 1'b1, 1'b1, 0, 0, 0, "perr");
    run_frame(4'b0001, 1'b1, 1'b0, 0, 0, 0, "ferr");
    run_frame(4'b1100, 1'b0, 1'b1, 0, 0, 6, "bp");
    run_frame(4'b0011, 1'b0, 1'b1, 0, 0, 0, "after_bp");

    for (int v = 0; v < 16; v++) begin
      d = 4'(v);
      run_frame(d, ^d, 1'b1, 2, 2, 0, "sweep");
    end

    for (int k = 0; k < 40; k++) begin
      d = 4'($urandom_range(15, 0));
      p = (^d) ^ ($urandom_range(3, 0) == 0);
      s = ($urandom_range(3, 0) != 0);
      run_frame(d, p, s, 0, 3, $urandom_range(3, 0), "rand");
    end

    strobe(1'b0, 0, 1);
    strobe(1'b1, 0, 1);
    strobe(1'b1, 0, 1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    exp_cnt = 0;
    check_reset_state("midrst");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      check_eq("midrst.idle_valid", 32'(bus.valid), 32'd0);
    end
    run_frame(4'b0101, 1'b0, 1'b1, 0, 1, 0, "post_rst");

    for (int k = 0; k < 5; k++) begin
      d = 4'($urandom_range(15, 0));
      run_frame(d, ~(^d), 1'b1, 0, 1, 0, "sat");
    end
`ifdef PARITY_ERR_CNT_EN
    check_eq("sat.final", 32'(bus.err_count), 32'd3);
`else
    check_eq("sat.final", 32'(bus.err_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
